// File: rtl/apb_image_loader.sv
// Bus initiator that streams an image into the pixel register file, kicks it via address 0,
// and serves CPU readbacks. Optional readback checksum verify under APB_LOADER_VERIFY_EN.
module apb_image_loader #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 13,
  parameter int unsigned Img_Words       = 1024,
  parameter int unsigned Base_Addr       = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       go,
  input  logic [Amba_Word-1:0]       start_cmd,
  input  logic [Amba_Word-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       rd_req,
  input  logic [Amba_Addr_Depth:0]   rd_addr,
  output logic [Amba_Word-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [1:0]                 control,
  output logic [Amba_Addr_Depth:0]   address,
  output logic [Amba_Word-1:0]       WriteData,
  input  logic [Amba_Word-1:0]       ReadData,
  input  logic [Amba_Word-1:0]       Start_work_reg,
  output logic                       busy,
  output logic                       done,
`ifdef APB_LOADER_VERIFY_EN
  output logic                       verify_err,
`endif
  output logic                       start_err
);

  localparam int unsigned AW = Amba_Addr_Depth + 1;
  localparam int unsigned CW = $clog2(Img_Words + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StKick, StConfirm, StDone, StRdIssue, StRdWait, StVerify
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           control_q, control_d;
  logic [AW-1:0]        address_q, address_d;
  logic [Amba_Word-1:0] wdata_q, wdata_d;
  logic [Amba_Word-1:0] cmd_q, cmd_d;
  logic [Amba_Word-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 start_err_q, start_err_d;
  logic [CW-1:0]        word_cnt_q, word_cnt_d;
  logic [AW-1:0]        addr_cnt_q, addr_cnt_d;
  logic [2:0]           to_cnt_q, to_cnt_d;
  logic                 accept;
  logic                 match;

`ifdef APB_LOADER_VERIFY_EN
  logic [Amba_Word-1:0] xacc_q, xacc_d;
  logic [Amba_Word-1:0] vacc_q, vacc_d;
  logic                 verify_err_q, verify_err_d;
  logic [Amba_Word-1:0] vfold;
  assign vfold      = vacc_q ^ ReadData;
  assign verify_err = verify_err_q;
`endif

  assign in_ready  = (state_q == StLoad) && (word_cnt_q < CW'(Img_Words));
  assign accept    = in_valid && in_ready;
  assign match     = (Start_work_reg == cmd_q);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign control   = control_q;
  assign address   = address_q;
  assign WriteData = wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign start_err = start_err_q;

  always_comb begin
    state_d     = state_q;
    control_d   = 2'b00;
    address_d   = address_q;
    wdata_d     = wdata_q;
    cmd_d       = cmd_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    start_err_d = start_err_q;
    word_cnt_d  = word_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    to_cnt_d    = to_cnt_q;
`ifdef APB_LOADER_VERIFY_EN
    xacc_d       = xacc_q;
    vacc_d       = vacc_q;
    verify_err_d = verify_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d     = StLoad;
          cmd_d       = start_cmd;
          word_cnt_d  = '0;
          addr_cnt_d  = AW'(Base_Addr);
          start_err_d = 1'b0;
`ifdef APB_LOADER_VERIFY_EN
          xacc_d       = '0;
          verify_err_d = 1'b0;
`endif
        end else if (rd_req && !rd_valid_q) begin
          // rd_req is still high while rd_valid pulses; skip it so one request gives one read
          state_d   = StRdIssue;
          control_d = 2'b10;
          address_d = rd_addr;
        end
      end
      StLoad: begin
        if (accept) begin
          control_d  = 2'b01;
          address_d  = addr_cnt_q;
          wdata_d    = in_data;
          addr_cnt_d = addr_cnt_q + AW'(1);
          word_cnt_d = word_cnt_q + CW'(1);
`ifdef APB_LOADER_VERIFY_EN
          xacc_d = xacc_q ^ in_data;
`endif
          if (word_cnt_q == CW'(Img_Words - 1)) state_d = StKick;
        end
      end
      StKick: begin
        control_d = 2'b01;
        address_d = '0;
        wdata_d   = cmd_q;
        to_cnt_d  = '0;
        state_d   = StConfirm;
      end
      StConfirm: begin
        to_cnt_d = to_cnt_q + 3'd1;
        if (match || (to_cnt_q == 3'd7)) begin
          if (!match) start_err_d = 1'b1;
`ifdef APB_LOADER_VERIFY_EN
          state_d    = StVerify;
          control_d  = 2'b10;
          address_d  = AW'(Base_Addr);
          word_cnt_d = '0;
          vacc_d     = '0;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef APB_LOADER_VERIFY_EN
      StVerify: begin
        // word_cnt_q==k: read k is on the bus, data of read k-1 is on ReadData
        if (word_cnt_q != '0) vacc_d = vfold;
        if (word_cnt_q == CW'(Img_Words)) begin
          verify_err_d = (vfold != xacc_q);
          state_d      = StDone;
        end else begin
          word_cnt_d = word_cnt_q + CW'(1);
          if (word_cnt_q < CW'(Img_Words - 1)) begin
            control_d = 2'b10;
            address_d = AW'(Base_Addr) + AW'(word_cnt_q) + AW'(1);
          end
        end
      end
`endif
      StDone:    state_d = StIdle;
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        rd_data_d  = ReadData;
        rd_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      control_q   <= 2'b00;
      address_q   <= '0;
      wdata_q     <= '0;
      cmd_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      start_err_q <= 1'b0;
      word_cnt_q  <= '0;
      addr_cnt_q  <= '0;
      to_cnt_q    <= '0;
`ifdef APB_LOADER_VERIFY_EN
      xacc_q       <= '0;
      vacc_q       <= '0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      control_q   <= control_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      cmd_q       <= cmd_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      start_err_q <= start_err_d;
      word_cnt_q  <= word_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      to_cnt_q    <= to_cnt_d;
`ifdef APB_LOADER_VERIFY_EN
      xacc_q       <= xacc_d;
      vacc_q       <= vacc_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_image_loader.sv
// Directed bench for apb_image_loader with a small behavioural register-file model.
module tb_apb_image_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [23:0] start_cmd = '0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rd_req = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [1:0]  control;
  logic [13:0] address;
  logic [23:0] WriteData;
  logic [23:0] ReadData;
  logic [23:0] Start_work_reg;
  logic        busy, done, start_err;
`ifdef APB_LOADER_VERIFY_EN
  logic        verify_err;
`endif

  apb_image_loader #(
    .Amba_Word(24), .Amba_Addr_Depth(13), .Img_Words(4), .Base_Addr(1)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .start_cmd(start_cmd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .control(control), .address(address), .WriteData(WriteData),
    .ReadData(ReadData), .Start_work_reg(Start_work_reg),
    .busy(busy), .done(done),
`ifdef APB_LOADER_VERIFY_EN
    .verify_err(verify_err),
`endif
    .start_err(start_err)
  );

  always #5 clock = ~clock;

  // Register-file model: writes land at the edge, Start_work_reg trails mem[0] by one more edge
  logic [23:0] mem [16];
  bit          ignore0 = 1'b0;
  bit          corrupt = 1'b0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      ReadData       <= '0;
      Start_work_reg <= '0;
    end else begin
      if (control == 2'b01 && !(ignore0 && address == 14'd0))
        mem[address[3:0]] <= (corrupt && address == 14'd2) ? 24'hB3 : WriteData;
      if (control == 2'b10) ReadData <= mem[address[3:0]];
      Start_work_reg <= ignore0 ? 24'h0 : mem[0];
    end
  end

  int          cyc = 0;
  int          done_cyc = 0;
  int          rd_cyc = 0;
  logic [37:0] wq [$];
  logic [13:0] rq [$];
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (!reset && control == 2'b01) wq.push_back({address, WriteData});
    if (!reset && control == 2'b10) begin
      rq.push_back(address);
      rd_cyc = cyc;
    end
    if (done) done_cyc = cyc;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [23:0] sw [$];
  bit          sv [$];
  int          accepted;
  logic        last_ready;

  task automatic start(input logic [23:0] cmd, input bit with_rd);
    @(negedge clock);
    go = 1'b1;
    start_cmd = cmd;
    if (with_rd) begin
      rd_req  = 1'b1;
      rd_addr = 14'd3;
    end
    @(posedge clock);
    #1 go = 1'b0;
  endtask

  task automatic send();
    int  idx = 0;
    bit  acc;
    for (int k = 0; k < sv.size(); k++) begin
      @(negedge clock);
      in_valid   = sv[k] && (idx < sw.size());
      in_data    = (idx < sw.size()) ? sw[idx] : 24'h0;
      last_ready = in_ready;
      acc        = in_valid && in_ready;
      @(posedge clock);
      if (acc) idx++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    accepted = idx;
  endtask

  task automatic wait_done(output int pulses);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) pulses++;
      if (!busy) break;
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [13:0] a,
                            input logic [23:0] d);
    logic [37:0] b;
    b = (idx < wq.size()) ? wq[idx] : 38'h3FFFFFFFFF;
    check({tag, "_addr"}, 32'(b[37:24]), 32'(a));
    check({tag, "_data"}, 32'(b[23:0]), 32'(d));
  endtask

  int pulses;

  initial begin
    // Reset and idle
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_control", 32'(control), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_start_err", 32'(start_err), 0);

    // Reset in the middle of a load
    start(24'h000007, 1'b0);
    sw = '{24'h11, 24'h22};
    sv = '{1'b1, 1'b1};
    send();
    check("midrst_pre_control", 32'(control), 1);
    reset = 1'b1;
    #1;
    check("midrst_control", 32'(control), 0);
    check("midrst_address", 32'(address), 0);
    check("midrst_wdata", 32'(WriteData), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_done", 32'(done), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Back-to-back load
    wq.delete();
    start(24'h000001, 1'b0);
    sw = '{24'hA1, 24'hB2, 24'hC3, 24'hD4};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1};
    send();
    wait_done(pulses);
    check("b2b_accepted", 32'(accepted), 4);
    check("b2b_beats", 32'(wq.size()), 5);
    check_beat("b2b_w0", 0, 14'd1, 24'hA1);
    check_beat("b2b_w1", 1, 14'd2, 24'hB2);
    check_beat("b2b_w2", 2, 14'd3, 24'hC3);
    check_beat("b2b_w3", 3, 14'd4, 24'hD4);
    check_beat("b2b_kick", 4, 14'd0, 24'h000001);
    check("b2b_done_pulses", 32'(pulses), 1);
    check("b2b_start_err", 32'(start_err), 0);
    check("b2b_busy_end", 32'(busy), 0);
`ifdef APB_LOADER_VERIFY_EN
    check("b2b_verify_err", 32'(verify_err), 0);
`endif

    // Load with valid gaps and a fifth offered word
    wq.delete();
    start(24'h000002, 1'b0);
    sw = '{24'hE1, 24'hE2, 24'hE3, 24'hE4, 24'hE5};
    sv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    send();
    check("gap_accepted", 32'(accepted), 4);
    check("gap_ready_after_4th", 32'(last_ready), 0);
    wait_done(pulses);
    check("gap_beats", 32'(wq.size()), 5);
    check_beat("gap_w0", 0, 14'd1, 24'hE1);
    check_beat("gap_w3", 3, 14'd4, 24'hE4);
    check_beat("gap_kick", 4, 14'd0, 24'h000002);
    check("gap_done_pulses", 32'(pulses), 1);

    // Start_work_reg never confirms
    ignore0 = 1'b1;
    start(24'h000055, 1'b0);
    sw = '{24'h01, 24'h02, 24'h03, 24'h04};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1};
    send();
    wait_done(pulses);
    check("to_done_pulses", 32'(pulses), 1);
    check("to_start_err", 32'(start_err), 1);
    check("to_busy_end", 32'(busy), 0);
    repeat (2) @(negedge clock);
    check("to_start_err_sticky", 32'(start_err), 1);
    ignore0 = 1'b0;

    // go and rd_req together: load first, then the read
    wq.delete();
    rq.delete();
    start(24'h000001, 1'b1);
    check("gord_start_err_clr", 32'(start_err), 0);
    check("gord_busy", 32'(busy), 1);
    sw = '{24'hA1, 24'hB2, 24'hC3, 24'hD4};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1};
    send();
    wait_done(pulses);
    check("gord_done_pulses", 32'(pulses), 1);
    check("gord_load_beats", 32'(wq.size()), 5);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rd_valid) begin
        pulses = 1;
        break;
      end
    end
    check("gord_rd_valid_seen", 32'(pulses), 1);
    check("gord_rd_data", 32'(rd_data), 32'h0000C3);
    check("gord_rd_addr", (rq.size() > 0) ? 32'(rq[rq.size() - 1]) : 32'hFFFF, 3);
    check("gord_rd_after_done", 32'(rd_cyc > done_cyc), 1);
    rd_req = 1'b0;
    @(negedge clock);
    check("gord_rd_valid_pulse", 32'(rd_valid), 0);
    repeat (3) @(negedge clock);
    check("gord_no_second_read", 32'(busy), 0);

`ifdef APB_LOADER_VERIFY_EN
    corrupt = 1'b1;
    start(24'h000001, 1'b0);
    sw = '{24'hA1, 24'hB2, 24'hC3, 24'hD4};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1};
    send();
    wait_done(pulses);
    check("ver_corrupt_err", 32'(verify_err), 1);
    corrupt = 1'b0;
    start(24'h000001, 1'b0);
    check("ver_err_clr_on_go", 32'(verify_err), 0);
    send();
    wait_done(pulses);
    check("ver_clean_err", 32'(verify_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
